// File: rtl/nn_pkg.sv
// Shared definitions for the small fixed-point NN layer blocks.
// Holds the state encoding, accumulator width and int8 saturation.
package nn_pkg;

  localparam int FRAC_DEF = 4;
  localparam int ACC_W    = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC0 = 2'd1,
    ST_MAC1 = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Clamp an accumulator value into the int8 range
  function automatic logic signed [7:0] sat8(
    input logic signed [ACC_W-1:0] x
  );
    if (x > 13'sd127)
      return 8'sd127;
    if (x < -13'sd128)
      return -8'sd128;
    return x[7:0];
  endfunction

endpackage

// File: rtl/nn_layer1_act.sv
// Saturate a layer accumulator to int8 and apply the activation.
// RELU=1 zeroes negative results, RELU=0 passes them through.
module nn_layer1_act
  import nn_pkg::*;
#(
  parameter int RELU = 1
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [7:0]       y
);

  logic signed [7:0] s;

  // Saturation followed by optional ReLU
  always_comb begin
    s = sat8(acc);
    y = s;
    if (RELU != 0 && s[7])
      y = '0;
  end

endmodule

// File: rtl/nn_layer1.sv
// Two-neuron fixed-point layer with a four-state MAC sequencer.
// One shared multiplier pair serves neuron 0 then neuron 1.
module nn_layer1
  import nn_pkg::*;
#(
  parameter int FRAC = FRAC_DEF,
  parameter int W00  = 16,
  parameter int W01  = -8,
  parameter int W10  = 32,
  parameter int W11  = 4,
  parameter int B0   = 3,
  parameter int B1   = -10,
  parameter int RELU = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_layer,
  input  logic signed [7:0] a0_in,
  input  logic signed [7:0] a1_in,
  output logic signed [7:0] y0,
  output logic signed [7:0] y1,
  output logic              ack_layer,
  output logic              busy
);

  localparam logic signed [7:0] W00_S = 8'(W00);
  localparam logic signed [7:0] W01_S = 8'(W01);
  localparam logic signed [7:0] W10_S = 8'(W10);
  localparam logic signed [7:0] W11_S = 8'(W11);
  localparam logic signed [7:0] B0_S  = 8'(B0);
  localparam logic signed [7:0] B1_S  = 8'(B1);

  state_t state;
  state_t state_nx;

  logic              req_q;
  logic              armed;
  logic              start;
  logic signed [7:0] a0_q;
  logic signed [7:0] a1_q;
  logic signed [7:0] w_a;
  logic signed [7:0] w_b;
  logic signed [7:0] bias;
  logic signed [15:0] p_a;
  logic signed [15:0] p_b;
  logic signed [15:0] s_a;
  logic signed [15:0] s_b;
  logic signed [ACC_W-1:0] mac;
  logic signed [ACC_W-1:0] acc0;
  logic signed [ACC_W-1:0] acc1;
  logic signed [7:0] y0_nx;
  logic signed [7:0] y1_nx;

  // armed stays low after reset until req_layer is seen low,
  // so a request held across reset cannot start a computation
  assign start = (state == ST_IDLE) && req_layer
              && !req_q && armed;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Next-state: single-cycle walk through the MAC phases
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_MAC0;
      ST_MAC0: state_nx = ST_MAC1;
      ST_MAC1: state_nx = ST_OUT;
      ST_OUT:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Shared MAC: coefficient set chosen by the current phase
  always_comb begin
    w_a  = W00_S;
    w_b  = W01_S;
    bias = B0_S;
    if (state == ST_MAC1) begin
      w_a  = W10_S;
      w_b  = W11_S;
      bias = B1_S;
    end
    p_a = 16'(a0_q) * 16'(w_a);
    p_b = 16'(a1_q) * 16'(w_b);
    s_a = p_a >>> FRAC;
    s_b = p_b >>> FRAC;
    mac = ACC_W'(s_a) + ACC_W'(s_b) + ACC_W'(bias);
  end

  nn_layer1_act #(.RELU(RELU)) u_act0 (
    .acc (acc0),
    .y   (y0_nx)
  );

  nn_layer1_act #(.RELU(RELU)) u_act1 (
    .acc (acc1),
    .y   (y1_nx)
  );

  // Datapath: edge detect, operand latch, accumulators, outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q     <= 1'b0;
      armed     <= 1'b0;
      a0_q      <= '0;
      a1_q      <= '0;
      acc0      <= '0;
      acc1      <= '0;
      y0        <= '0;
      y1        <= '0;
      ack_layer <= 1'b0;
    end else begin
      req_q <= req_layer;
      if (!req_layer)
        armed <= 1'b1;
      if (start) begin
        a0_q      <= a0_in;
        a1_q      <= a1_in;
        ack_layer <= 1'b0;
      end
      if (state == ST_MAC0)
        acc0 <= mac;
      if (state == ST_MAC1)
        acc1 <= mac;
      if (state == ST_OUT) begin
        y0        <= y0_nx;
        y1        <= y1_nx;
        ack_layer <= 1'b1;
      end
    end
  end

endmodule
